pingpong_game_core: RTL and testbench

- Game core of the 8-LED ping-pong box.
- Debounces the two player buttons and generates the internal 0.5 s ball-step tick from the 50 MHz clock.
- Runs the serve/rally/score state machine and drives a one-hot ball position plus two 3-bit scores.
- Sits between the raw board buttons and the LED/7-segment display drivers.

---
 rtl/pingpong_game_core_if.sv | 25 ++
 rtl/pingpong_game_core.sv | 189 ++++++++++++++++++
 tb/tb_pingpong_game_core.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pingpong_game_core_if.sv
// Board-side signal bundle of the ping-pong game core: raw buttons in,
// ball LED position and both player scores out.
interface pingpong_game_core_if;
  logic       key_1;
  logic       key_2;
  logic [7:0] position;
  logic [2:0] score_player1;
  logic [2:0] score_player2;

  modport master (
    output key_1,
    output key_2,
    input  position,
    input  score_player1,
    input  score_player2
  );

  modport slave (
    input  key_1,
    input  key_2,
    output position,
    output score_player1,
    output score_player2
  );
endinterface

// File: rtl/pingpong_game_core.sv
// Ping-pong game core: key debounce, ball-step tick generation and the
// serve/rally/score state machine driving a one-hot ball and two scores.
module pingpong_game_core #(
  parameter int unsigned TICK_CYCLES     = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned WIN_SCORE       = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  pingpong_game_core_if.slave  game
);

  localparam int unsigned POS_W   = 8;
  localparam int unsigned SCORE_W = 3;
  localparam int unsigned TICK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
  localparam logic [POS_W-1:0]   POS_P1    = 8'h80;
  localparam logic [POS_W-1:0]   POS_P2    = 8'h01;

  typedef enum logic [2:0] {
    SERVE1 = 3'd0,
    SERVE2 = 3'd1,
    MOVE_R = 3'd2,
    MOVE_L = 3'd3,
    OVER   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Ball-step tick
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_c;

  always_comb begin : tick_comb
    tick_c     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Key filters, index 0 = player 1, index 1 = player 2
  // ---------------------------------------------------------------------------
  logic [1:0]            key_raw_c;
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            armed_q, armed_d;
  logic [1:0]            press_q, press_d;
  logic [1:0][CNT_W-1:0] low_cnt_q, low_cnt_d;

  assign key_raw_c = {game.key_2, game.key_1};

  // Sync flops reset low so a key held through reset stays disarmed until released.
  always_comb begin : key_comb
    sync1_d   = key_raw_c;
    sync2_d   = sync1_q;
    armed_d   = armed_q;
    low_cnt_d = low_cnt_q;
    press_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i]) begin
        low_cnt_d[i] = '0;
        armed_d[i]   = 1'b1;
      end else if (armed_q[i]) begin
        if (low_cnt_q[i] == DEB_LAST) begin
          press_d[i] = 1'b1;
          armed_d[i] = 1'b0;
        end else begin
          low_cnt_d[i] = low_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Game state machine
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [POS_W-1:0]     position_q, position_d;
  logic [SCORE_W-1:0]   score1_q, score1_d;
  logic [SCORE_W-1:0]   score2_q, score2_d;
  logic                 point_p1_c, point_p2_c;
  logic                 p1_c, p2_c;

  assign p1_c = press_q[0];
  assign p2_c = press_q[1];

  // Receiver's press outranks a same-cycle tick; the other player's press is ignored.
  always_comb begin : fsm_comb
    state_d    = state_q;
    position_d = position_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    point_p1_c = 1'b0;
    point_p2_c = 1'b0;

    case (state_q)
      SERVE1: begin
        if (p1_c) state_d = MOVE_R;
      end
      SERVE2: begin
        if (p2_c) state_d = MOVE_L;
      end
      MOVE_R: begin
        if (p2_c) begin
          if (position_q == POS_P2) state_d = MOVE_L;
          else                      point_p1_c = 1'b1;
        end else if (tick_c) begin
          if (position_q == POS_P2) point_p1_c = 1'b1;
          else                      position_d = position_q >> 1;
        end
      end
      MOVE_L: begin
        if (p1_c) begin
          if (position_q == POS_P1) state_d = MOVE_R;
          else                      point_p2_c = 1'b1;
        end else if (tick_c) begin
          if (position_q == POS_P1) point_p2_c = 1'b1;
          else                      position_d = position_q << 1;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d    = SERVE1;
        position_d = POS_P1;
      end
    endcase

    // Loser of the point serves next; reaching the win score ends the game.
    if (point_p1_c) begin
      score1_d = score1_q + SCORE_W'(1);
      if (score1_d == WIN_S) begin
        state_d    = OVER;
        position_d = '0;
      end else begin
        state_d    = SERVE2;
        position_d = POS_P2;
      end
    end
    if (point_p2_c) begin
      score2_d = score2_q + SCORE_W'(1);
      if (score2_d == WIN_S) begin
        state_d    = OVER;
        position_d = '0;
      end else begin
        state_d    = SERVE1;
        position_d = POS_P1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin : regs
    if (!rst) begin
      tick_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      armed_q    <= '0;
      press_q    <= '0;
      low_cnt_q  <= '0;
      state_q    <= SERVE1;
      position_q <= POS_P1;
      score1_q   <= '0;
      score2_q   <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      armed_q    <= armed_d;
      press_q    <= press_d;
      low_cnt_q  <= low_cnt_d;
      state_q    <= state_d;
      position_q <= position_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
    end
  end

  assign game.position      = position_q;
  assign game.score_player1 = score1_q;
  assign game.score_player2 = score2_q;

endmodule

// File: tb/tb_pingpong_game_core.sv
// Directed bench for pingpong_game_core with TICK_CYCLES=10, DEBOUNCE_CYCLES=4.
// "now" counts clock edges since the last reset edge; ticks land on edges 10, 20, ...
module tb_pingpong_game_core;

  logic clk;
  logic rst;
  int   now;
  int   n_asserts;
  int   n_fail;
  int   t_pt;

  pingpong_game_core_if gif ();

  pingpong_game_core #(
    .TICK_CYCLES     (10),
    .DEBOUNCE_CYCLES (4),
    .WIN_SCORE       (7)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .game (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic goto(input int c);
    while (now < c) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    now = 0;
    rst = 1'b1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] pos,
                           input logic [2:0] s1, input logic [2:0] s2);
    check({tag, ".pos"}, gif.position, pos);
    check({tag, ".s1"}, {5'd0, gif.score_player1}, {5'd0, s1});
    check({tag, ".s2"}, {5'd0, gif.score_player2}, {5'd0, s2});
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    now       = 0;
    rst       = 1'b0;
    gif.key_1 = 1'b1;
    gif.key_2 = 1'b1;

    // 1: idle after reset, ticks must not move a parked ball
    do_reset();
    check_all("t1_reset", 8'h80, 3'd0, 3'd0);
    goto(100);
    check_all("t1_idle", 8'h80, 3'd0, 3'd0);

    // 2: wrong-player press, short bounce, then a real serve
    gif.key_2 = 1'b0;
    goto(120); gif.key_2 = 1'b1;
    goto(130); check_all("t2_p2_serve1", 8'h80, 3'd0, 3'd0);
    gif.key_1 = 1'b0;
    goto(133); gif.key_1 = 1'b1;
    goto(145); check("t2_bounce", gif.position, 8'h80);
    goto(150); gif.key_1 = 1'b0;
    goto(159); check("t2_parked", gif.position, 8'h80);
    goto(160); check("t2_step1", gif.position, 8'h40);
    goto(170); check("t2_step2", gif.position, 8'h20);
    gif.key_1 = 1'b1;
    goto(180); check("t2_step3", gif.position, 8'h10);

    // 3: early hit by player 2, then early hit by player 1
    do_reset();
    goto(10); gif.key_1 = 1'b0;
    goto(20); check("t3_serve", gif.position, 8'h40);
    goto(28); gif.key_2 = 1'b0;
    goto(30); gif.key_1 = 1'b1;
    goto(34); check_all("t3_pre_foul2", 8'h20, 3'd0, 3'd0);
    goto(35); check_all("t3_foul2", 8'h01, 3'd1, 3'd0);
    goto(40); gif.key_2 = 1'b1;
    goto(45); check("t3_serve2_held", gif.position, 8'h01);
    goto(50); gif.key_2 = 1'b0;
    goto(60); gif.key_2 = 1'b1;
    check("t3_ml_step1", gif.position, 8'h02);
    goto(68); gif.key_1 = 1'b0;
    goto(74); check_all("t3_pre_foul1", 8'h04, 3'd1, 3'd0);
    goto(75); check_all("t3_foul1", 8'h80, 3'd1, 3'd1);
    goto(80); gif.key_1 = 1'b1;
    goto(95); check("t3_serve1_held", gif.position, 8'h80);

    // 4: valid return at bit0, player 1 misses at bit7
    do_reset();
    goto(10); gif.key_1 = 1'b0;
    goto(20); gif.key_1 = 1'b1;
    goto(78); gif.key_2 = 1'b0;
    goto(85); check_all("t4_return", 8'h01, 3'd0, 3'd0);
    goto(89); check("t4_hold_bit0", gif.position, 8'h01);
    goto(90); check("t4_back1", gif.position, 8'h02);
    gif.key_2 = 1'b1;
    goto(100); check("t4_back2", gif.position, 8'h04);
    goto(159); check_all("t4_at_bit7", 8'h80, 3'd0, 3'd0);
    goto(160); check_all("t4_miss1", 8'h80, 3'd0, 3'd1);
    goto(175); check("t4_serve1", gif.position, 8'h80);

    // 5: player 2 misses seven times; game over freezes everything
    do_reset();
    goto(10); gif.key_1 = 1'b0;
    goto(20); gif.key_1 = 1'b1;
    t_pt = 90;
    for (int i = 0; i < 7; i++) begin
      goto(t_pt + 1);
      check_all($sformatf("t5_point%0d", i + 1), (i == 6) ? 8'h00 : 8'h01,
                3'(i + 1), 3'd0);
      if (i < 6) begin
        gif.key_2 = 1'b0;
        goto(t_pt + 11); gif.key_2 = 1'b1;
        goto(t_pt + 71); gif.key_1 = 1'b0;
        goto(t_pt + 81); gif.key_1 = 1'b1;
      end
      t_pt += 150;
    end
    goto(1000); gif.key_1 = 1'b0; gif.key_2 = 1'b0;
    goto(1020); gif.key_1 = 1'b1; gif.key_2 = 1'b1;
    goto(1050); check_all("t5_over_frozen", 8'h00, 3'd7, 3'd0);
    do_reset();
    check_all("t5_reset_over", 8'h80, 3'd0, 3'd0);

    // 6: simultaneous presses at bit0, then reset mid-rally
    do_reset();
    goto(10); gif.key_1 = 1'b0;
    goto(20); gif.key_1 = 1'b1;
    goto(78); gif.key_1 = 1'b0; gif.key_2 = 1'b0;
    goto(85); check_all("t6_both_return", 8'h01, 3'd0, 3'd0);
    goto(90); check("t6_moving_left", gif.position, 8'h02);
    gif.key_1 = 1'b1; gif.key_2 = 1'b1;
    goto(95);
    do_reset();
    check_all("t6_mid_reset", 8'h80, 3'd0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
